mmu_banked: RTL and testbench
=============================

MMU_BANKED -- requirements
Module: mmu_banked

Interface
REQ-001 SHALL have parameter LANES, default 8, meaning number of byte lanes (independent 8-bit banks).
REQ-002 SHALL have parameter DEPTH_LOG, default 10, meaning log2 of words per bank.
REQ-003 SHALL have parameter ADDR_W, default 29, meaning request word-address width; ADDR_W > DEPTH_LOG+1.
REQ-004 clk  in  1  sole clock, all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  request accepted when req_valid && req_ready.
REQ-008 req_we  in  1  1=write, 0=read.
REQ-009 req_addr  in  ADDR_W  word address.
REQ-010 req_ben  in  LANES  active-low byte enables; bit i gates lane i.
REQ-011 req_wdata  in  8*LANES  write data; lane i = bits [8i+7:8i].
REQ-012 rsp_valid  out  1  response present.
REQ-013 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
REQ-014 rsp_rdata  out  8*LANES  read data.
REQ-015 rsp_err  out  1  response is a decode error.
REQ-016 fault  out  1  sticky error flag (MMU_FAULT_EN only).
REQ-017 fault_addr  out  ADDR_W  address of first faulting request (MMU_FAULT_EN only).

Function
REQ-018 Main-memory hit SHALL be: req_addr[ADDR_W-1]==0 and req_addr[ADDR_W-2:DEPTH_LOG]==0; all other addresses are decode errors.
REQ-019 Storage SHALL be LANES banks of 2^DEPTH_LOG x 8 bits, indexed by req_addr[DEPTH_LOG-1:0], synchronous read.
REQ-020 On accepted hit write, lane i SHALL be written iff req_ben[i]==0; other lanes unchanged; all-ones req_ben writes nothing but still responds.
REQ-021 On accepted hit read, rsp_rdata lane i SHALL be stored byte if req_ben[i]==0, else 8'h00.
REQ-022 Every accepted request SHALL produce exactly one response, in order; rsp_valid rises the cycle after acceptance (latency 1).
REQ-023 Write responses and error responses SHALL return rsp_rdata = 0; rsp_err=1 only for decode errors.
REQ-024 Decode-error requests SHALL not modify storage.
REQ-025 Response stage is one entry: req_ready SHALL equal !rsp_valid || rsp_ready (combinational); back-to-back requests at one per cycle when rsp_ready held high.
REQ-026 While rsp_valid && !rsp_ready, rsp_rdata/rsp_err SHALL hold stable; held read data must not be disturbed by later bank activity (capture into output register).
REQ-027 Simultaneous response consume and new accept SHALL replace response next cycle with no bubble.
REQ-028 Read after write to same address in consecutive cycles SHALL return the newly written bytes.

Reset
REQ-029 With reset high at a clk edge: rsp_valid=0, rsp_err=0, rsp_rdata=0, fault=0, fault_addr=0; req_ready=1 the following cycle.
REQ-030 Reset SHALL NOT clear storage contents; a request presented during reset SHALL be ignored (no write, no response).
REQ-031 Reset asserted with a response pending SHALL drop that response.

Configuration
REQ-032 Macro MMU_FAULT_EN: when defined, fault sets on the first accepted decode-error request, fault_addr captures its req_addr; both hold until reset; later errors do not overwrite.
REQ-033 Without MMU_FAULT_EN, fault and fault_addr SHALL be tied to 0 and no capture registers exist; all other behaviour identical.

Verification
REQ-034 Reset, write addr 0x5 data 0x0807060504030201 ben 8'h00, read addr 0x5 ben 8'h00 -> rsp_rdata 0x0807060504030201, rsp_err 0, one cycle after each accept.
REQ-035 Write addr 0x5 data all 0xFF ben 8'hF0, read ben 8'h00 -> 0x08070605FFFFFFFF; read ben 8'h0F -> 0x0807060500000000.
REQ-036 Read addr 0x10000000 (bit 28 set) -> rsp_err 1, rsp_rdata 0; with MMU_FAULT_EN fault=1, fault_addr=0x10000000; second error at 0x400 leaves fault_addr unchanged.
REQ-037 Read hit, hold rsp_ready=0 for 5 cycles -> req_ready 0, rsp_rdata stable; raise rsp_ready with new request valid -> next response follows with no idle cycle.
REQ-038 Stream 16 writes then 16 reads at full rate, rsp_ready=1 -> 32 in-order responses, data matches, no gaps.
REQ-039 Assert reset with response pending -> rsp_valid 0 next cycle; previously written addr 0x5 still reads back 0x08070605FFFFFFFF.

Source files
------------

// File: rtl/mmu_banked.sv
// mmu_banked: single-port banked memory with byte-lane masking and a
// one-entry response register. Addresses outside the bank range return
// a decode-error response and never touch storage.
// Optional feature: define MMU_FAULT_EN to add a sticky fault flag that
// captures the address of the first decode-error request.
module mmu_banked #(
   parameter int LANES     = 8,
   parameter int DEPTH_LOG = 10,
   parameter int ADDR_W    = 29
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [ADDR_W-1:0]    req_addr,
   input  logic [LANES-1:0]     req_ben,
   input  logic [8*LANES-1:0]   req_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [8*LANES-1:0]   rsp_rdata,
   output logic                 rsp_err,
   output logic                 fault,
   output logic [ADDR_W-1:0]    fault_addr
);

   localparam int DEPTH = 2 ** DEPTH_LOG;

   // Storage: one 8-bit bank per lane, never reset.
   logic [7:0] mem_q [LANES][DEPTH];

   logic                 rsp_valid_q, rsp_valid_d;
   logic                 rsp_err_q,   rsp_err_d;
   logic [8*LANES-1:0]   rsp_rdata_q, rsp_rdata_d;

   logic                 hit_s;
   logic                 accept_s;
   logic                 wr_en_s;
   logic [DEPTH_LOG-1:0] idx_s;

   // The response slot frees up when empty or being consumed this cycle.
   assign req_ready = !rsp_valid_q || rsp_ready;
   // A request seen while reset is high is dropped entirely.
   assign accept_s  = req_valid && req_ready && !reset;
   assign hit_s     = (req_addr[ADDR_W-1:DEPTH_LOG] == '0);
   assign idx_s     = req_addr[DEPTH_LOG-1:0];
   assign wr_en_s   = accept_s && hit_s && req_we;

   // Bank writes: only enabled (active-low) lanes of an accepted hit write.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         for (int i = 0; i < LANES; i++) begin
            if (!req_ben[i]) begin
               mem_q[i][idx_s] <= req_wdata[8*i +: 8];
            end
         end
      end
   end

   // Next response: a new accept replaces the slot, a consume empties it,
   // otherwise the held response (data included) stays put.
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      if (accept_s) begin
         rsp_valid_d = 1'b1;
         rsp_err_d   = !hit_s;
         rsp_rdata_d = '0;
         if (hit_s && !req_we) begin
            for (int i = 0; i < LANES; i++) begin
               if (!req_ben[i]) begin
                  rsp_rdata_d[8*i +: 8] = mem_q[i][idx_s];
               end else begin
                  rsp_rdata_d[8*i +: 8] = 8'h00;
               end
            end
         end else begin
            rsp_rdata_d = '0;
         end
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end else begin
         rsp_valid_d = rsp_valid_q;
      end
   end

   // Response register; reset drops any pending response.
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

`ifdef MMU_FAULT_EN
   logic              fault_q, fault_d;
   logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;

   // Capture only the first decode error; later ones leave it untouched.
   always_comb begin
      fault_d      = fault_q;
      fault_addr_d = fault_addr_q;
      if (accept_s && !hit_s && !fault_q) begin
         fault_d      = 1'b1;
         fault_addr_d = req_addr;
      end else begin
         fault_d      = fault_q;
      end
   end

   // Sticky fault registers, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         fault_q      <= 1'b0;
         fault_addr_q <= '0;
      end else begin
         fault_q      <= fault_d;
         fault_addr_q <= fault_addr_d;
      end
   end

   assign fault      = fault_q;
   assign fault_addr = fault_addr_q;
`else
   assign fault      = 1'b0;
   assign fault_addr = '0;
`endif

endmodule

// File: tb/tb_mmu_banked.sv
// Directed self-checking bench for mmu_banked (default parameters).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_mmu_banked;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [28:0] req_addr;
   logic [7:0]  req_ben;
   logic [63:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_rdata;
   logic        rsp_err;
   logic        fault;
   logic [28:0] fault_addr;

   int total_cnt;
   int bad_cnt;

   mmu_banked dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_ben    (req_ben),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .fault      (fault),
      .fault_addr (fault_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      total_cnt++;
      if (obs !== exp_v) begin
         bad_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One request with rsp_ready high; checks the response one cycle later.
   task automatic do_req(input string tag, input logic we, input logic [28:0] addr,
                         input logic [7:0] ben, input logic [63:0] wdata,
                         input logic [63:0] exp_data, input logic exp_err);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_ben   = ben;
      req_wdata = wdata;
      step();
      req_valid = 1'b0;
      chk({tag, "_vld"}, 64'(rsp_valid), 64'd1);
      chk({tag, "_err"}, 64'(rsp_err), 64'(exp_err));
      chk({tag, "_dat"}, rsp_rdata, exp_data);
   endtask

   initial begin
      total_cnt = 0;
      bad_cnt   = 0;
      reset     = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 29'h0;
      req_ben   = 8'hFF;
      req_wdata = 64'h0;
      rsp_ready = 1'b1;
      step();
      step();
      chk("rst_vld",   64'(rsp_valid),  64'd0);
      chk("rst_err",   64'(rsp_err),    64'd0);
      chk("rst_dat",   rsp_rdata,       64'd0);
      chk("rst_flt",   64'(fault),      64'd0);
      chk("rst_faddr", 64'(fault_addr), 64'd0);
      reset = 1'b0;
      step();
      chk("rst_rdy",   64'(req_ready),  64'd1);

      // Basic full write / read.
      do_req("wr5",   1'b1, 29'h5, 8'h00, 64'h0807060504030201, 64'h0, 1'b0);
      do_req("rd5",   1'b0, 29'h5, 8'h00, 64'h0, 64'h0807060504030201, 1'b0);
      // Partial write of lanes 0..3 and masked reads.
      do_req("wrp",   1'b1, 29'h5, 8'hF0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b0);
      do_req("rdp",   1'b0, 29'h5, 8'h00, 64'h0, 64'h08070605FFFFFFFF, 1'b0);
      do_req("rdm",   1'b0, 29'h5, 8'h0F, 64'h0, 64'h0807060500000000, 1'b0);
      // All-ones enables: nothing written, still responds.
      do_req("wrnone", 1'b1, 29'h5, 8'hFF, 64'h1234123412341234, 64'h0, 1'b0);

      // Decode errors.
      do_req("err1",  1'b0, 29'h10000000, 8'h00, 64'h0, 64'h0, 1'b1);
`ifdef MMU_FAULT_EN
      chk("flt1",  64'(fault),      64'd1);
      chk("fadr1", 64'(fault_addr), 64'h10000000);
`else
      chk("flt1",  64'(fault),      64'd0);
      chk("fadr1", 64'(fault_addr), 64'd0);
`endif
      do_req("err2",  1'b0, 29'h400, 8'h00, 64'h0, 64'h0, 1'b1);
      // Error write aliasing index 5 must not touch storage.
      do_req("errwr", 1'b1, 29'h405, 8'h00, 64'h1111111111111111, 64'h0, 1'b1);
`ifdef MMU_FAULT_EN
      chk("flt2",  64'(fault),      64'd1);
      chk("fadr2", 64'(fault_addr), 64'h10000000);
`else
      chk("flt2",  64'(fault),      64'd0);
      chk("fadr2", 64'(fault_addr), 64'd0);
`endif
      do_req("rdkeep", 1'b0, 29'h5, 8'h00, 64'h0, 64'h08070605FFFFFFFF, 1'b0);
      step();
      chk("idle_vld", 64'(rsp_valid), 64'd0);

      // Backpressure: held read response, then no-bubble replacement.
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 29'h5;
      req_ben   = 8'h00;
      step();
      req_we    = 1'b1;
      req_addr  = 29'h6;
      req_wdata = 64'h1122334455667788;
      for (int c = 0; c < 5; c++) begin
         chk("bp_rdy", 64'(req_ready), 64'd0);
         chk("bp_vld", 64'(rsp_valid), 64'd1);
         chk("bp_dat", rsp_rdata, 64'h08070605FFFFFFFF);
         step();
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_rdy1", 64'(req_ready), 64'd1);
      step();
      req_valid = 1'b0;
      chk("nb_vld", 64'(rsp_valid), 64'd1);
      chk("nb_dat", rsp_rdata, 64'h0);
      do_req("rd6", 1'b0, 29'h6, 8'h00, 64'h0, 64'h1122334455667788, 1'b0);

      // Full-rate stream: 16 writes then 16 reads, one per cycle.
      for (int k = 0; k < 33; k++) begin
         if (k > 0) begin
            chk("st_vld", 64'(rsp_valid), 64'd1);
            if (k - 1 < 16) begin
               chk("st_wdat", rsp_rdata, 64'h0);
            end else begin
               chk("st_rdat", rsp_rdata, 64'h0101010101010101 * 64'(k - 16));
            end
         end
         if (k < 32) begin
            req_valid = 1'b1;
            req_we    = (k < 16);
            req_addr  = 29'(16 + (k % 16));
            req_ben   = 8'h00;
            req_wdata = 64'h0101010101010101 * 64'((k % 16) + 1);
            step();
         end else begin
            req_valid = 1'b0;
         end
      end
      step();
      chk("st_end", 64'(rsp_valid), 64'd0);

      // Reset with a response pending; a write presented during reset is ignored.
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 29'h5;
      req_ben   = 8'h00;
      step();
      chk("pre_vld", 64'(rsp_valid), 64'd1);
      reset     = 1'b1;
      req_we    = 1'b1;
      req_wdata = 64'hDEADBEEFDEADBEEF;
      step();
      chk("rp_vld", 64'(rsp_valid), 64'd0);
      chk("rp_rdy", 64'(req_ready), 64'd1);
      reset     = 1'b0;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      step();
      chk("rp_none", 64'(rsp_valid), 64'd0);
      do_req("rp_rd5", 1'b0, 29'h5, 8'h00, 64'h0, 64'h08070605FFFFFFFF, 1'b0);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
